gray_step_encoder: RTL and testbench

Sequential binary-to-Gray encoder that produces the 4-bit Gray code consumed by the board's Gray-to-binary decode and display path.
- Two raw push-buttons step an internal binary count up or down, one step per press.
- A load port presets the count directly.
- The block drives both the registered binary count and its registered Gray encoding, plus a one-cycle change strobe.
- It sits between the board buttons and the existing Gray input of the display chain, replacing the DIP-switch Gray source.

---
 rtl/gray_pkg.sv | 18 +
 rtl/gray_step_encoder_if.sv | 23 ++
 rtl/btn_debounce.sv | 44 ++++
 rtl/gray_step_encoder.sv | 88 ++++++++
 tb/tb_gray_step_encoder.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the button-driven Gray code source.
// Also holds the default debounce length used by the display path.
package gray_pkg;

    localparam int GRAY_MAX_WIDTH          = 32;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 270000;

    typedef enum logic {
        IDLE,
        WAIT_RELEASE
    } step_state_t;

    // Callers zero-extend their value; truncating the result keeps it correct for any width.
    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_step_encoder_if.sv
// Button, load and count/Gray signals of the step encoder.
// The master side drives buttons and load; the slave side is the encoder.
interface gray_step_encoder_if #(
    parameter int WIDTH = 4
);
    logic             btn_up;
    logic             btn_down;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] gray;
    logic             step_pulse;

    modport master (
        output btn_up, btn_down, load, load_bin,
        input  bin, gray, step_pulse
    );

    modport slave (
        input  btn_up, btn_down, load, load_bin,
        output bin, gray, step_pulse
    );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a debouncer for one raw push-button.
// The debounced level flips only after the input has differed from it for DEBOUNCE_CYCLES cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_deb
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_meta_reg;
    logic             sync_reg;
    logic             deb_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_reg <= 1'b0;
            sync_reg      <= 1'b0;
        end else begin
            sync_meta_reg <= btn_raw;
            sync_reg      <= sync_meta_reg;
        end
    end

    // Any cycle that agrees with the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (sync_reg == deb_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_reg <= sync_reg;
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign btn_deb = deb_reg;
endmodule

// File: rtl/gray_step_encoder.sv
// Steps a binary count up/down from debounced buttons, with synchronous load,
// and registers its Gray encoding in the same stage so both always agree.
module gray_step_encoder
    import gray_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    gray_step_encoder_if.slave bus
);
    logic [1:0] btn_raw;
    logic [1:0] btn_deb;

    assign btn_raw = {bus.btn_down, bus.btn_up};

    // Bit 0 is the up button, bit 1 the down button.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_btn_debounce (
                .clk    (clk),
                .rst_n  (rst_n),
                .btn_raw(btn_raw[gi]),
                .btn_deb(btn_deb[gi])
            );
        end
    endgenerate

    step_state_t      state_reg, state_next;
    logic [WIDTH-1:0] bin_reg, bin_next;
    logic [WIDTH-1:0] gray_reg, gray_next;
    logic             pulse_reg, pulse_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            bin_reg   <= '0;
            gray_reg  <= '0;
            pulse_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            bin_reg   <= bin_next;
            gray_reg  <= gray_next;
            pulse_reg <= pulse_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        bin_next   = bin_reg;
        pulse_next = 1'b0;
        if (bus.load) begin
            // Load wins and parks the FSM so a held button cannot step afterwards.
            bin_next   = bus.load_bin;
            state_next = WAIT_RELEASE;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (btn_deb[0] && !btn_deb[1]) begin
                        bin_next   = bin_reg + WIDTH'(1);
                        pulse_next = 1'b1;
                        state_next = WAIT_RELEASE;
                    end else if (btn_deb[1] && !btn_deb[0]) begin
                        bin_next   = bin_reg - WIDTH'(1);
                        pulse_next = 1'b1;
                        state_next = WAIT_RELEASE;
                    end else if (btn_deb[0] && btn_deb[1]) begin
                        state_next = WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!btn_deb[0] && !btn_deb[1]) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
        gray_next = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_next)));
    end

    assign bus.bin        = bin_reg;
    assign bus.gray       = gray_reg;
    assign bus.step_pulse = pulse_reg;
endmodule

// File: tb/tb_gray_step_encoder.sv
// Directed bench for gray_step_encoder with a 4-cycle debounce and 4-bit count.
module tb_gray_step_encoder;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    gray_step_encoder_if #(.WIDTH(4)) bus ();

    gray_step_encoder #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;
    int pulse_cnt     = 0;
    int pulse_base    = 0;

    always @(negedge clk) begin
        if (bus.step_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_out(input string tag, input logic [3:0] b, input logic [3:0] g,
                             input logic p);
        check({tag, ".bin"},   32'(bus.bin),        32'(b));
        check({tag, ".gray"},  32'(bus.gray),       32'(g));
        check({tag, ".pulse"}, 32'(bus.step_pulse), 32'(p));
    endtask

    task automatic press(input logic up, input logic down, input int hold);
        bus.btn_up   = up;
        bus.btn_down = down;
        repeat (hold) tick();
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        repeat (12) tick();
        $display("press up=%0b down=%0b hold=%0d -> bin=%b gray=%b", up, down, hold,
                 bus.bin, bus.gray);
    endtask

    task automatic do_load(input logic [3:0] v);
        bus.load     = 1'b1;
        bus.load_bin = v;
        tick();
        bus.load     = 1'b0;
        $display("load %b -> bin=%b gray=%b", v, bus.bin, bus.gray);
    endtask

    initial begin
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        bus.load     = 1'b0;
        bus.load_bin = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        check_out("reset", 4'b0000, 4'b0000, 1'b0);

        repeat (20) tick();
        check_out("idle20", 4'b0000, 4'b0000, 1'b0);
        check("idle20.pulses", 32'(pulse_cnt), 32'd0);

        // First press: update lands on the 7th edge after the button is raised.
        pulse_base = pulse_cnt;
        bus.btn_up = 1'b1;
        repeat (6) tick();
        check_out("up1.before", 4'b0000, 4'b0000, 1'b0);
        tick();
        check_out("up1.edge7", 4'b0001, 4'b0001, 1'b1);
        tick();
        check_out("up1.after", 4'b0001, 4'b0001, 1'b0);
        repeat (2) tick();
        bus.btn_up = 1'b0;
        repeat (12) tick();
        $display("press up hold=10 -> bin=%b gray=%b", bus.bin, bus.gray);
        press(1'b1, 1'b0, 10);
        check_out("up2", 4'b0010, 4'b0011, 1'b0);
        check("up.pulses", 32'(pulse_cnt - pulse_base), 32'd2);

        do_load(4'b0000);
        tick();
        pulse_base = pulse_cnt;
        press(1'b0, 1'b1, 10);
        check_out("down.wrap", 4'b1111, 4'b1000, 1'b0);
        check("down.pulses", 32'(pulse_cnt - pulse_base), 32'd1);
        do_load(4'b1011);
        check_out("load", 4'b1011, 4'b1110, 1'b0);
        tick();

        pulse_base = pulse_cnt;
        press(1'b1, 1'b0, 3);
        check_out("glitch", 4'b1011, 4'b1110, 1'b0);
        press(1'b1, 1'b1, 10);
        check_out("both", 4'b1011, 4'b1110, 1'b0);
        check("glitch_both.pulses", 32'(pulse_cnt - pulse_base), 32'd0);
        press(1'b1, 1'b0, 50);
        check_out("hold50", 4'b1100, 4'b1010, 1'b0);
        check("hold50.pulses", 32'(pulse_cnt - pulse_base), 32'd1);

        // Load during a held press must not be followed by another step.
        bus.btn_up = 1'b1;
        repeat (10) tick();
        check_out("held.step", 4'b1101, 4'b1011, 1'b0);
        do_load(4'b0011);
        check_out("held.load", 4'b0011, 4'b0010, 1'b0);
        pulse_base = pulse_cnt;
        repeat (20) tick();
        check_out("held.after", 4'b0011, 4'b0010, 1'b0);
        bus.btn_up = 1'b0;
        repeat (12) tick();
        check_out("held.release", 4'b0011, 4'b0010, 1'b0);
        check("held.pulses", 32'(pulse_cnt - pulse_base), 32'd0);
        press(1'b1, 1'b0, 10);
        check_out("held.newpress", 4'b0100, 4'b0110, 1'b0);

        // Reset while waiting for release, with the button still held.
        bus.btn_up = 1'b1;
        repeat (10) tick();
        check_out("rst.pre", 4'b0101, 4'b0111, 1'b0);
        rst_n = 1'b0;
        #1;
        check_out("rst.async", 4'b0000, 4'b0000, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check_out("rst.redeb", 4'b0000, 4'b0000, 1'b0);
        tick();
        check_out("rst.step", 4'b0001, 4'b0001, 1'b1);
        bus.btn_up = 1'b0;
        repeat (12) tick();
        $display("reset re-press -> bin=%b gray=%b", bus.bin, bus.gray);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
